// File: rtl/linear_layer_backward_if.sv
// Handshake bundle for the linear-layer backward engine.
// The master side supplies weights, output gradients and the consumer ready.
// The slave side (the engine) returns input gradients and status.
interface linear_layer_backward_if #(
    parameter int IN_DIM  = 3,
    parameter int OUT_DIM = 2,
    parameter int DATA_W  = 16
);
    logic [OUT_DIM*IN_DIM*DATA_W-1:0] w_flat;
    logic                             in_valid;
    logic                             in_ready;
    logic [OUT_DIM*DATA_W-1:0]        grad_out_flat;
    logic                             out_valid;
    logic                             out_ready;
    logic [IN_DIM*DATA_W-1:0]         grad_in_flat;
    logic                             busy;

    modport master (
        output w_flat, in_valid, grad_out_flat, out_ready,
        input  in_ready, out_valid, grad_in_flat, busy
    );

    modport slave (
        input  w_flat, in_valid, grad_out_flat, out_ready,
        output in_ready, out_valid, grad_in_flat, busy
    );
endinterface

// File: rtl/linear_layer_backward.sv
// Backward pass of one fully connected layer: grad_in = W^T * grad_out.
// A single multiply-accumulate unit walks the weight matrix column by column
// (j outer, i inner), so a result vector takes IN_DIM*OUT_DIM cycles.
// Inputs are snapshotted at accept; the output port only changes when the
// complete new vector is ready.
module linear_layer_backward #(
    parameter int IN_DIM  = 3,
    parameter int OUT_DIM = 2,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    linear_layer_backward_if.slave  bus
);
    localparam int I_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int J_W    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int PROD_W = 2 * DATA_W;
    // Headroom for OUT_DIM worst-case products plus sign; cannot overflow.
    localparam int ACC_W  = 2 * DATA_W + $clog2(OUT_DIM) + 1;

    localparam logic signed [ACC_W-1:0]  RND_ADD = ACC_W'(1) << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Unpacked views of the flat input buses
    logic signed [DATA_W-1:0] w_g_in [OUT_DIM];
    logic signed [DATA_W-1:0] w_w_in [OUT_DIM][IN_DIM];

    // Snapshot of the accepted transaction and working state
    logic signed [DATA_W-1:0] r_g    [OUT_DIM];
    logic signed [DATA_W-1:0] r_w    [OUT_DIM][IN_DIM];
    logic signed [DATA_W-1:0] r_work [IN_DIM];
    logic [I_W-1:0]           r_i;
    logic [J_W-1:0]           r_j;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IN_DIM*DATA_W-1:0] r_out_flat;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_rnd;
    logic signed [ACC_W-1:0]  w_shr;
    logic signed [DATA_W-1:0] w_sat;
    logic [IN_DIM*DATA_W-1:0] w_res_flat;
    logic                     w_last_i;
    logic                     w_last_j;
    logic                     w_accept;
    logic                     w_in_ready;
    logic                     w_out_valid;
    logic                     w_busy;

    genvar gi, gj;
    generate
        for (gi = 0; gi < OUT_DIM; gi++) begin : g_unpack_row
            assign w_g_in[gi] = bus.grad_out_flat[gi*DATA_W +: DATA_W];
            for (gj = 0; gj < IN_DIM; gj++) begin : g_unpack_col
                assign w_w_in[gi][gj] = bus.w_flat[(gi*IN_DIM+gj)*DATA_W +: DATA_W];
            end
        end
    endgenerate

    assign w_last_i = (r_i == I_W'(OUT_DIM - 1));
    assign w_last_j = (r_j == J_W'(IN_DIM - 1));

    // MAC datapath: product, accumulate, round half toward +inf, saturate
    always_comb begin
        w_prod = PROD_W'(r_g[r_i]) * PROD_W'(r_w[r_i][r_j]);
        w_sum  = r_acc + ACC_W'(w_prod);
        w_rnd  = w_sum + RND_ADD;
        w_shr  = w_rnd >>> FRAC_W;
        if (w_shr > SAT_MAX) begin
            w_sat = D_MAX;
        end else if (w_shr < SAT_MIN) begin
            w_sat = D_MIN;
        end else begin
            w_sat = w_shr[DATA_W-1:0];
        end
    end

    // Full result vector with the element currently being finished merged in
    always_comb begin
        w_res_flat = '0;
        for (int k = 0; k < IN_DIM; k++) begin
            w_res_flat[k*DATA_W +: DATA_W] = (r_j == J_W'(k)) ? w_sat : r_work[k];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_busy = 1'b1;
                if (w_last_i && w_last_j) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Snapshot at accept, step the (j, i) walk, publish the vector at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < OUT_DIM; a++) begin
                r_g[a] <= '0;
                for (int b = 0; b < IN_DIM; b++) begin
                    r_w[a][b] <= '0;
                end
            end
            for (int b = 0; b < IN_DIM; b++) begin
                r_work[b] <= '0;
            end
            r_i        <= '0;
            r_j        <= '0;
            r_acc      <= '0;
            r_out_flat <= '0;
        end else if (w_accept) begin
            r_g   <= w_g_in;
            r_w   <= w_w_in;
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
        end else if (r_state == ST_ACCUM) begin
            if (w_last_i) begin
                r_work[r_j] <= w_sat;
                r_acc       <= '0;
                r_i         <= '0;
                if (w_last_j) begin
                    r_j        <= '0;
                    r_out_flat <= w_res_flat;
                end else begin
                    r_j <= r_j + J_W'(1);
                end
            end else begin
                r_acc <= w_sum;
                r_i   <= r_i + I_W'(1);
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.busy         = w_busy;
    assign bus.grad_in_flat = r_out_flat;

endmodule

// File: tb/tb_linear_layer_backward.sv
// Randomized and directed bench for linear_layer_backward against a plain
// arithmetic model of grad_in = sat(round(W^T * grad_out)).
module tb_linear_layer_backward;
    localparam int IN_DIM  = 3;
    localparam int OUT_DIM = 2;
    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int LAT     = IN_DIM * OUT_DIM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linear_layer_backward_if #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W)) bus ();

    linear_layer_backward #(
        .IN_DIM (IN_DIM),
        .OUT_DIM(OUT_DIM),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     tb_g [OUT_DIM];
    int     tb_w [OUT_DIM][IN_DIM];
    longint exp_r [IN_DIM];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot products, then round and clamp
    function automatic void model();
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -(longint'(1) << (DATA_W - 1));
        for (int j = 0; j < IN_DIM; j++) begin
            s = 0;
            for (int i = 0; i < OUT_DIM; i++) begin
                s += longint'(tb_g[i]) * longint'(tb_w[i][j]);
            end
            s = (s + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            exp_r[j] = s;
        end
    endfunction

    function automatic longint r_elem(input int j);
        logic signed [DATA_W-1:0] v;
        v = bus.grad_in_flat[j*DATA_W +: DATA_W];
        return longint'(v);
    endfunction

    task automatic drive_vec();
        for (int i = 0; i < OUT_DIM; i++) begin
            bus.grad_out_flat[i*DATA_W +: DATA_W] = tb_g[i][DATA_W-1:0];
            for (int j = 0; j < IN_DIM; j++) begin
                bus.w_flat[(i*IN_DIM+j)*DATA_W +: DATA_W] = tb_w[i][j][DATA_W-1:0];
            end
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < OUT_DIM; i++) begin
            bus.grad_out_flat[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            for (int j = 0; j < IN_DIM; j++) begin
                bus.w_flat[(i*IN_DIM+j)*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic set_default_w();
        tb_w[0][0] = 20;  tb_w[0][1] = -39; tb_w[0][2] = 46;
        tb_w[1][0] = -44; tb_w[1][1] = 94;  tb_w[1][2] = -79;
    endtask

    task automatic start_txn(input string tag);
        model();
        @(negedge clk);
        drive_vec();
        bus.in_valid = 1'b1;
        check({tag, ":in_ready_before"}, longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble();
        check({tag, ":busy_after_accept"}, longint'(bus.busy), 1);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, longint'(lat), longint'(LAT));
        for (int j = 0; j < IN_DIM; j++) begin
            check($sformatf("%s:r%0d", tag, j), r_elem(j), exp_r[j]);
        end
        check({tag, ":in_ready_done"}, longint'(bus.in_ready), 0);
        $display("txn %s g={%0d,%0d} r={%0d,%0d,%0d} exp={%0d,%0d,%0d} lat=%0d", tag,
                 tb_g[0], tb_g[1], r_elem(0), r_elem(1), r_elem(2),
                 exp_r[0], exp_r[1], exp_r[2], lat);
    endtask

    task automatic handshake(input string tag, input int delay);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            #1;
            check({tag, ":hold_valid"}, longint'(bus.out_valid), 1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ":valid_drop"}, longint'(bus.out_valid), 0);
        check({tag, ":in_ready_back"}, longint'(bus.in_ready), 1);
        check({tag, ":busy_drop"}, longint'(bus.busy), 0);
    endtask

    initial begin
        longint snap;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        bus.grad_out_flat = '0;
        bus.w_flat        = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst:in_ready", longint'(bus.in_ready), 1);
        check("rst:out_valid", longint'(bus.out_valid), 0);
        check("rst:busy", longint'(bus.busy), 0);
        check("rst:grad_in", longint'(bus.grad_in_flat), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray out_ready while idle is ignored
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("idle_ready:out_valid", longint'(bus.out_valid), 0);

        // Directed: unit row select, both rows
        set_default_w();
        tb_g[0] = 256; tb_g[1] = 0;
        start_txn("t1"); wait_result("t1"); handshake("t1", 0);
        tb_g[0] = 256; tb_g[1] = 256;
        start_txn("t2"); wait_result("t2"); handshake("t2", 0);

        // Rounding half toward +inf
        tb_w[0][0] = 128; tb_w[0][1] = 127; tb_w[0][2] = -128;
        tb_w[1][0] = 0;   tb_w[1][1] = 0;   tb_w[1][2] = 0;
        tb_g[0] = 1; tb_g[1] = 0;
        start_txn("t3"); wait_result("t3"); handshake("t3", 1);

        // Saturation high and low
        for (int i = 0; i < OUT_DIM; i++) for (int j = 0; j < IN_DIM; j++) tb_w[i][j] = 32767;
        tb_g[0] = 32767; tb_g[1] = 32767;
        start_txn("t4p"); wait_result("t4p"); handshake("t4p", 0);
        for (int i = 0; i < OUT_DIM; i++) for (int j = 0; j < IN_DIM; j++) tb_w[i][j] = -32768;
        start_txn("t4n"); wait_result("t4n"); handshake("t4n", 0);

        // Backpressure with a pending new request
        set_default_w();
        tb_g[0] = 256; tb_g[1] = 256;
        start_txn("t5a"); wait_result("t5a");
        snap = longint'(bus.grad_in_flat);
        tb_g[0] = 256; tb_g[1] = 0;
        model();
        @(negedge clk);
        drive_vec();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("t5:stall_valid", longint'(bus.out_valid), 1);
            check("t5:stall_data", longint'(bus.grad_in_flat), snap);
            check("t5:stall_in_ready", longint'(bus.in_ready), 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5:release_valid", longint'(bus.out_valid), 0);
        check("t5:release_in_ready", longint'(bus.in_ready), 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("t5:accepted", longint'(bus.busy), 1);
        bus.in_valid = 1'b0;
        scramble();
        wait_result("t5b"); handshake("t5b", 0);

        // Reset during the third accumulate cycle
        tb_g[0] = 256; tb_g[1] = 0;
        start_txn("t6a");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6:out_valid", longint'(bus.out_valid), 0);
        check("t6:grad_in", longint'(bus.grad_in_flat), 0);
        check("t6:in_ready", longint'(bus.in_ready), 1);
        check("t6:busy", longint'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_txn("t6b"); wait_result("t6b"); handshake("t6b", 0);

        // Random transactions with random consumer delay
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < OUT_DIM; i++) begin
                tb_g[i] = int'($urandom_range(0, 65535)) - 32768;
                for (int j = 0; j < IN_DIM; j++) begin
                    tb_w[i][j] = (n < 6) ? int'($urandom_range(0, 1023)) - 512
                                         : int'($urandom_range(0, 65535)) - 32768;
                end
            end
            start_txn($sformatf("rnd%0d", n));
            wait_result($sformatf("rnd%0d", n));
            handshake($sformatf("rnd%0d", n), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
